// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-file geometry, PC step and the
// index/word types used across the register bank.
package cpu_pkg;

    localparam int REGISTER_SIZE       = 32;
    localparam int AMOUNT_OF_REGISTERS = 16;
    localparam int PC_INCREMENT        = 4;
    localparam int INDEX_WIDTH         = $clog2(AMOUNT_OF_REGISTERS);

    typedef logic [INDEX_WIDTH-1:0]   reg_idx_t;
    typedef logic [REGISTER_SIZE-1:0] word_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: a load takes priority over an increment, and the increment
// wraps modulo 2^RegisterSize without any overflow indication.
module pc_register
    import cpu_pkg::*;
#(
    parameter int RegisterSize = REGISTER_SIZE,
    parameter int PCIncrement  = PC_INCREMENT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pc_increment,
    input  logic                    pc_load,
    input  logic [RegisterSize-1:0] pc_load_value,
    output logic [RegisterSize-1:0] pc_value
);

    logic [RegisterSize-1:0] pc_q;
    logic [RegisterSize-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_load_value;
        end else if (pc_increment) begin
            pc_d = pc_q + RegisterSize'(PCIncrement);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_value = pc_q;

endmodule

// File: rtl/register_bank.sv
// General register file with one registered read port, a write port, a
// register-to-register MOV port, and the program counter.
module register_bank
    import cpu_pkg::*;
#(
    parameter int RegisterSize      = REGISTER_SIZE,
    parameter int AmountOfRegisters = AMOUNT_OF_REGISTERS,
    parameter int PCIncrement       = PC_INCREMENT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writeEnable,
    input  reg_idx_t                writeRegister,
    input  logic [RegisterSize-1:0] writeValue,
    input  logic                    movEnable,
    input  reg_idx_t                MOVRegisterOrigin,
    input  reg_idx_t                MOVRegisterDestiny,
    input  logic                    readEnable,
    input  reg_idx_t                readRegister,
    output logic [RegisterSize-1:0] readValue,
    output logic                    readValid,
    input  logic                    pcIncrement,
    input  logic                    pcLoad,
    input  logic [RegisterSize-1:0] pcLoadValue,
    output logic [RegisterSize-1:0] PC_Read
);

    // Read handshake: readEnable samples readRegister on an edge; readValid is
    // high for exactly the following cycle, while readValue carries that data.
    // readValue holds its last value whenever readValid is low.

    logic [RegisterSize-1:0] regs_q [AmountOfRegisters];
    logic [RegisterSize-1:0] regs_d [AmountOfRegisters];
    logic [RegisterSize-1:0] read_value_q;
    logic [RegisterSize-1:0] read_value_d;
    logic                    read_valid_q;
    logic                    read_valid_d;
    logic [RegisterSize-1:0] mov_value;
    logic                    mov_commit;

    always_comb begin
        regs_d       = regs_q;
        mov_value    = '0;
        read_value_d = read_value_q;
        read_valid_d = readEnable;

        // MOV always copies the pre-edge source; indices beyond the bank read as 0.
        for (int i = 0; i < AmountOfRegisters; i++) begin
            if (MOVRegisterOrigin == reg_idx_t'(i)) begin
                mov_value = regs_q[i];
            end
        end

        mov_commit = movEnable
                  && (MOVRegisterOrigin != MOVRegisterDestiny)
                  && !(writeEnable && (writeRegister == MOVRegisterDestiny));

        for (int i = 0; i < AmountOfRegisters; i++) begin
            if (writeEnable && (writeRegister == reg_idx_t'(i))) begin
                regs_d[i] = writeValue;
            end else if (mov_commit && (MOVRegisterDestiny == reg_idx_t'(i))) begin
                regs_d[i] = mov_value;
            end
        end

        // Reading from the next-state array gives write-first bypass for free.
        if (readEnable) begin
            read_value_d = '0;
            for (int i = 0; i < AmountOfRegisters; i++) begin
                if (readRegister == reg_idx_t'(i)) begin
                    read_value_d = regs_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AmountOfRegisters; i++) begin
                regs_q[i] <= '0;
            end
            read_value_q <= '0;
            read_valid_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            read_value_q <= read_value_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign readValue = read_value_q;
    assign readValid = read_valid_q;

    pc_register #(
        .RegisterSize (RegisterSize),
        .PCIncrement  (PCIncrement)
    ) u_pc_register (
        .clk           (clk),
        .reset         (reset),
        .pc_increment  (pcIncrement),
        .pc_load       (pcLoad),
        .pc_load_value (pcLoadValue),
        .pc_value      (PC_Read)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: read results are checked by a scoreboard
// monitor; PC and reset behaviour are checked inline.
module tb_register_bank;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         writeEnable;
    logic [3:0]   writeRegister;
    logic [W-1:0] writeValue;
    logic         movEnable;
    logic [3:0]   MOVRegisterOrigin;
    logic [3:0]   MOVRegisterDestiny;
    logic         readEnable;
    logic [3:0]   readRegister;
    logic [W-1:0] readValue;
    logic         readValid;
    logic         pcIncrement;
    logic         pcLoad;
    logic [W-1:0] pcLoadValue;
    logic [W-1:0] PC_Read;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    register_bank dut (
        .clk                (clk),
        .reset              (reset),
        .writeEnable        (writeEnable),
        .writeRegister      (writeRegister),
        .writeValue         (writeValue),
        .movEnable          (movEnable),
        .MOVRegisterOrigin  (MOVRegisterOrigin),
        .MOVRegisterDestiny (MOVRegisterDestiny),
        .readEnable         (readEnable),
        .readRegister       (readRegister),
        .readValue          (readValue),
        .readValid          (readValid),
        .pcIncrement        (pcIncrement),
        .pcLoad             (pcLoad),
        .pcLoadValue        (pcLoadValue),
        .PC_Read            (PC_Read)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        movEnable   = 1'b0;
        readEnable  = 1'b0;
        pcIncrement = 1'b0;
        pcLoad      = 1'b0;
    endtask

    task automatic set_write(input logic [3:0] idx, input logic [W-1:0] val);
        writeEnable   = 1'b1;
        writeRegister = idx;
        writeValue    = val;
    endtask

    task automatic set_mov(input logic [3:0] org, input logic [3:0] dst);
        movEnable          = 1'b1;
        MOVRegisterOrigin  = org;
        MOVRegisterDestiny = dst;
    endtask

    task automatic set_read(input logic [3:0] idx, input logic [W-1:0] exp);
        readEnable   = 1'b1;
        readRegister = idx;
        exp_q.push_back(exp);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset && readValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got readValid with value 0x%08h, want no read outstanding", readValue);
            end else begin
                check("sb_read", readValue, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        writeEnable   = 1'b0;
        writeRegister = '0;
        writeValue    = '0;
        movEnable     = 1'b0;
        MOVRegisterOrigin  = '0;
        MOVRegisterDestiny = '0;
        readEnable    = 1'b0;
        readRegister  = '0;
        pcIncrement   = 1'b0;
        pcLoad        = 1'b0;
        pcLoadValue   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", PC_Read, 32'h0);
        check("reset_valid", W'(readValid), 32'h0);
        check("reset_value", readValue, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // write then read one cycle later, checking exact latency
        set_write(4'd3, 32'h0000_00A5); tick();
        set_read(4'd3, 32'h0000_00A5);  tick();
        check("lat_valid", W'(readValid), 32'h1);
        check("lat_value", readValue, 32'h0000_00A5);
        set_write(4'd5, 32'h0000_1234); set_read(4'd5, 32'h0000_1234); tick();

        // MOV uses pre-edge origin; write port wins a shared destination
        set_write(4'd1, 32'd7); tick();
        set_write(4'd2, 32'd9); tick();
        set_mov(4'd1, 4'd2); set_write(4'd1, 32'd11); tick();
        set_read(4'd2, 32'd7);  tick();
        set_read(4'd1, 32'd11); tick();
        set_mov(4'd1, 4'd2); set_write(4'd2, 32'd5); set_read(4'd2, 32'd5); tick();
        set_read(4'd2, 32'd5); tick();
        set_mov(4'd1, 4'd4); set_read(4'd4, 32'd11); tick();
        set_mov(4'd3, 4'd3); tick();
        set_read(4'd3, 32'h0000_00A5); tick();

        // PC increment, load priority, wrap
        repeat (4) begin
            pcIncrement = 1'b1; tick();
        end
        check("pc_inc4", PC_Read, 32'd16);
        pcLoad = 1'b1; pcLoadValue = 32'h100; pcIncrement = 1'b1; tick();
        check("pc_load_prio", PC_Read, 32'h100);
        pcIncrement = 1'b1; tick();
        check("pc_inc_after_load", PC_Read, 32'h104);
        pcLoad = 1'b1; pcLoadValue = 32'hFFFF_FFFC; tick();
        check("pc_load_top", PC_Read, 32'hFFFF_FFFC);
        pcIncrement = 1'b1; tick();
        check("pc_wrap", PC_Read, 32'h0);

        // back-to-back reads, then hold
        set_write(4'd1, 32'd1); tick();
        set_write(4'd2, 32'd2); tick();
        set_write(4'd3, 32'd3); tick();
        set_read(4'd1, 32'd1); tick();
        set_read(4'd2, 32'd2); tick();
        check("b2b_valid_mid", W'(readValid), 32'h1);
        set_read(4'd3, 32'd3); tick();
        check("b2b_valid_last", W'(readValid), 32'h1);
        tick();
        check("hold_valid", W'(readValid), 32'h0);
        check("hold_value", readValue, 32'd3);

        // asynchronous reset mid-operation; the write during reset is discarded
        pcLoad = 1'b1; pcLoadValue = 32'h40; tick();
        readEnable = 1'b1; readRegister = 4'd2; tick();
        check("pre_reset_valid", W'(readValid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", W'(readValid), 32'h0);
        check("async_value", readValue, 32'h0);
        check("async_pc", PC_Read, 32'h0);
        set_write(4'd2, 32'hDEAD_BEEF); pcIncrement = 1'b1; tick();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_read(4'(i), 32'h0); tick();
        end
        check("post_reset_pc", PC_Read, 32'h0);

        repeat (2) tick();
        check("sb_drained", W'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Register file stage directly downstream of the CPU control unit; sinks the CPU's Registers port group.
- Holds AmountOfRegisters general registers and a program counter (PC).
- Provides one registered read port, one write port, a register-to-register MOV port, and PC update and observe ports.
- All state updates on the rising edge of clk.

Parameters:
- RegisterSize, 32, width of every register and of PC.
- AmountOfRegisters, 16, number of general registers; index width is clog2 (4 at default).
- PCIncrement, 4, byte step added to PC on pcIncrement.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- writeEnable  input  1  commit writeValue into writeRegister this edge.
- writeRegister  input  4  write index.
- writeValue  input  RegisterSize  write data.
- movEnable  input  1  copy MOVRegisterOrigin into MOVRegisterDestiny this edge.
- MOVRegisterOrigin  input  4  MOV source index.
- MOVRegisterDestiny  input  4  MOV destination index.
- readEnable  input  1  sample readRegister this edge.
- readRegister  input  4  read index.
- readValue  output  RegisterSize  registered read data.
- readValid  output  1  pulses high the cycle readValue is updated.
- pcIncrement  input  1  PC <= PC + PCIncrement.
- pcLoad  input  1  PC <= pcLoadValue.
- pcLoadValue  input  RegisterSize  branch target.
- PC_Read  output  RegisterSize  current PC, registered.

Behaviour:
- Reset (reset low, asynchronous):
  - All registers = 0; PC = 0; readValue = 0; readValid = 0.
  - Reset asserted mid-operation discards any same-cycle write, MOV, read or PC update.
- Release is synchronised by the consumer; the first edge after reset goes high acts normally.
- Write: on an edge with writeEnable=1, reg[writeRegister] <= writeValue.
- MOV:
  - On an edge with movEnable=1, reg[MOVRegisterDestiny] <= reg[MOVRegisterOrigin], using the pre-edge value.
  - MOV with origin == destiny is a no-op.
- Simultaneous write and MOV:
  - Different destinations: both commit.
  - Same destination: the write port wins; the MOV is dropped.
  - MOV origin == writeRegister: MOV copies the OLD value (no forwarding into MOV).
- Read:
  - Latency 1. On an edge with readEnable=1, readValue <= value of reg[readRegister] and readValid <= 1.
  - Write-first bypass: if readRegister matches a same-edge write (or a committing MOV destination), readValue takes the new value. The write port has priority, mirroring the rule above.
  - readEnable=0: readValue holds its last value; readValid <= 0.
  - Back-to-back reads are allowed every cycle; each returns one cycle later.
- PC:
  - pcLoad has priority over pcIncrement.
  - PC wraps modulo 2^RegisterSize (0xFFFFFFFC + 4 = 0x00000000), with no overflow indication.
  - PC_Read reflects the PC register (updated value visible the cycle after the edge).
- Out-of-range index: when AmountOfRegisters < 2^index width, writes and MOVs to a nonexistent index are ignored, and reads from one return 0.
- No internal FSM beyond the read-valid pipeline bit. The consumer sequences multi-cycle operations (issue read, consume readValue on the readValid cycle).

Decomposition:
- Shared package (cpu_pkg): RegisterSize and AmountOfRegisters defaults, PCIncrement, register index typedef (logic [3:0]), word typedef (logic [RegisterSize-1:0]).
- One natural sub-module, pc_register: holds PC with the load/increment priority and wrap. register_bank instantiates it and exposes PC_Read.

Test Plan:
1. Reset then idle: drive reset low mid-simulation after writes -> all registers read back 0, PC_Read=0, readValid=0 immediately (asynchronously).
2. Write/read latency: write R3=0x0000_00A5, next cycle readEnable R3 -> readValue=0x0000_00A5 with readValid=1 exactly one edge later. Same-edge write R5=0x1234 plus read R5 -> returns 0x1234 via bypass.
3. MOV: R1=7, R2=9; movEnable origin=R1, destiny=R2 with the same-edge write R1=11 -> R2=7, R1=11. Repeat with write to R2=5 on the same edge as MOV into R2 -> R2=5.
4. PC: four pcIncrement pulses from reset -> PC_Read=16. pcLoad=0x100 together with pcIncrement -> PC_Read=0x100.
5. PC wrap: pcLoad 0xFFFF_FFFC then pcIncrement -> PC_Read=0x0000_0000.
6. Back-to-back reads: readEnable R1,R2,R3 on consecutive cycles (values 1,2,3) -> readValue 1,2,3 on the following three cycles with readValid held high; readEnable drops -> readValid=0 and readValue holds 3.
